// File: rtl/ascon_perm_arbiter.sv
// Round-robin arbiter and sequencer sharing one ASCON permutation core between
// the encryption (port 0) and decryption (port 1) engines, with a run watchdog.
module ascon_perm_arbiter #(
    parameter int STATE_W     = 320,
    parameter int ROUND_W     = 5,
    parameter int MAX_ROUNDS  = 12,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    input  logic [STATE_W-1:0] req0_state,
    input  logic [ROUND_W-1:0] req0_rounds,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [STATE_W-1:0] req1_state,
    input  logic [ROUND_W-1:0] req1_rounds,
    output logic               req1_ready,
    output logic               rsp0_valid,
    output logic [STATE_W-1:0] rsp0_state,
    output logic               rsp1_valid,
    output logic [STATE_W-1:0] rsp1_state,
    output logic               perm_start,
    output logic [STATE_W-1:0] perm_state,
    output logic [ROUND_W-1:0] perm_rounds,
    input  logic [STATE_W-1:0] perm_out,
    input  logic               perm_done,
    output logic [1:0]         grant,
    output logic               busy,
    output logic               err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_RUN   = 3'd2,
        ST_RESP  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    state_t             st_r;
    logic               ptr_r;
    logic               owner_r;
    logic [STATE_W-1:0] lat_state_r;
    logic [ROUND_W-1:0] lat_rounds_r;
    logic [STATE_W-1:0] resp_r;
    logic [6:0]         wd_r;
    logic               perm_start_r;
    logic               busy_r;
    logic [1:0]         grant_r;
    logic [1:0]         rsp_valid_r;

    logic any_s;
    logic win_s;
    logic bad_rounds_s;
    logic timeout_s;
    logic err_s;

    // Round-robin winner: the pointer only matters when both ports are pending
    always_comb begin
        any_s = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            win_s = ptr_r;
        end else if (req1_valid) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // Round-count legality and watchdog expiry decodes
    always_comb begin
        bad_rounds_s = (lat_rounds_r == {ROUND_W{1'b0}}) ||
                       (lat_rounds_r > ROUND_W'(MAX_ROUNDS));
        timeout_s    = (wd_r == 7'(TIMEOUT_CYC - 1));
    end

    // Error pulse: illegal rounds in CHECK, or watchdog expiry with no done in RUN
    always_comb begin
        if (st_r == ST_CHECK) begin
            err_s = bad_rounds_s;
        end else if (st_r == ST_RUN) begin
            err_s = timeout_s & ~perm_done;
        end else begin
            err_s = 1'b0;
        end
    end

    // Accept pulse is combinational so the winner's payload is sampled in the same cycle
    always_comb begin
        if ((st_r == ST_IDLE) && !rst && any_s) begin
            req0_ready = ~win_s;
            req1_ready = win_s;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // Sequencer FSM with registered core and response controls
    always_ff @(posedge clk) begin
        if (rst) begin
            st_r         <= ST_IDLE;
            ptr_r        <= 1'b0;
            owner_r      <= 1'b0;
            lat_state_r  <= {STATE_W{1'b0}};
            lat_rounds_r <= {ROUND_W{1'b0}};
            resp_r       <= {STATE_W{1'b0}};
            wd_r         <= 7'd0;
            perm_start_r <= 1'b0;
            busy_r       <= 1'b0;
            grant_r      <= 2'b00;
            rsp_valid_r  <= 2'b00;
        end else begin
            case (st_r)
                ST_IDLE: begin
                    if (any_s) begin
                        owner_r      <= win_s;
                        lat_state_r  <= win_s ? req1_state : req0_state;
                        lat_rounds_r <= win_s ? req1_rounds : req0_rounds;
                        busy_r       <= 1'b1;
                        grant_r      <= win_s ? 2'b10 : 2'b01;
                        st_r         <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (bad_rounds_s) begin
                        resp_r      <= lat_state_r;
                        rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
                        st_r        <= ST_RESP;
                    end else begin
                        wd_r         <= 7'd0;
                        perm_start_r <= 1'b1;
                        st_r         <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (perm_done) begin
                        resp_r       <= perm_out;
                        rsp_valid_r  <= owner_r ? 2'b10 : 2'b01;
                        perm_start_r <= 1'b0;
                        st_r         <= ST_RESP;
                    end else if (timeout_s) begin
                        perm_start_r <= 1'b0;
                        st_r         <= ST_ABORT;
                    end else if (wd_r != 7'h7f) begin
                        wd_r <= wd_r + 7'd1;
                    end
                end
                ST_RESP, ST_ABORT: begin
                    rsp_valid_r <= 2'b00;
                    busy_r      <= 1'b0;
                    grant_r     <= 2'b00;
                    ptr_r       <= ~ptr_r;
                    st_r        <= ST_IDLE;
                end
                default: begin
                    perm_start_r <= 1'b0;
                    busy_r       <= 1'b0;
                    grant_r      <= 2'b00;
                    rsp_valid_r  <= 2'b00;
                    st_r         <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp0_valid  = rsp_valid_r[0];
    assign rsp1_valid  = rsp_valid_r[1];
    assign rsp0_state  = rsp_valid_r[0] ? resp_r : {STATE_W{1'b0}};
    assign rsp1_state  = rsp_valid_r[1] ? resp_r : {STATE_W{1'b0}};
    assign perm_start  = perm_start_r;
    assign perm_state  = lat_state_r;
    assign perm_rounds = lat_rounds_r;
    assign grant       = grant_r;
    assign busy        = busy_r;
    assign err         = err_s;

endmodule

// File: tb/tb_ascon_perm_arbiter.sv
// Directed bench for ascon_perm_arbiter: a job-timeline model checked every cycle
// plus hand-computed latencies and result values.
module tb_ascon_perm_arbiter;

    localparam int SW = 320;
    localparam int RW = 5;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [SW-1:0] req0_state = '0, req1_state = '0;
    logic [RW-1:0] req0_rounds = '0, req1_rounds = '0;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [SW-1:0] rsp0_state, rsp1_state, perm_state, perm_out;
    logic          perm_start, perm_done, busy, err;
    logic [RW-1:0] perm_rounds;
    logic [1:0]    grant;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // core model controls
    logic done_mode = 1'b1;
    logic spur      = 1'b0;
    logic core_done = 1'b0;
    int   core_cnt  = 0;

    ascon_perm_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_state(req0_state), .req0_rounds(req0_rounds), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_state(req1_state), .req1_rounds(req1_rounds), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_state(rsp0_state),
        .rsp1_valid(rsp1_valid), .rsp1_state(rsp1_state),
        .perm_start(perm_start), .perm_state(perm_state), .perm_rounds(perm_rounds),
        .perm_out(perm_out), .perm_done(perm_done),
        .grant(grant), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // stand-in permutation: rotate left by one 64-bit word, xor rounds into the bottom
    function automatic logic [SW-1:0] perm_fn(input logic [SW-1:0] s, input logic [RW-1:0] r);
        logic [SW-1:0] rot;
        rot = {s[255:0], s[319:256]};
        return rot ^ {{(SW-RW){1'b0}}, r};
    endfunction

    // Core model: done after 'rounds' cycles of continuous start, unless stalled
    always @(posedge clk) begin
        #1;
        if (perm_start) core_cnt = core_cnt + 1;
        else core_cnt = 0;
        core_done = done_mode && perm_start && (core_cnt >= int'(perm_rounds));
    end
    assign perm_done = core_done | spur;
    assign perm_out  = spur ? {SW{1'b1}} : perm_fn(perm_state, perm_rounds);

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h required %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- job-timeline model ----------------
    logic          m_active = 1'b0;
    logic          m_ptr = 1'b0;
    logic          m_owner = 1'b0;
    logic          m_bad = 1'b0;
    logic [SW-1:0] m_state = '0;
    logic [RW-1:0] m_rounds = '0;
    int            m_tacc = 0, m_tdone = -1, m_tabort = -1;

    always @(negedge clk) begin
        logic          e_r0, e_r1, e_s0v, e_s1v, e_start, e_busy, e_err, retire;
        logic [1:0]    e_grant;
        logic [SW-1:0] e_s0, e_s1;
        int            k;
        if (rst) begin
            check("ready_in_rst", {318'd0, req1_ready, req0_ready}, '0);
            m_active = 1'b0; m_ptr = 1'b0; m_state = '0; m_rounds = '0;
        end else begin
            e_r0 = 0; e_r1 = 0; e_s0v = 0; e_s1v = 0; e_start = 0; e_busy = 0; e_err = 0;
            retire = 0; e_grant = 2'b00; e_s0 = '0; e_s1 = '0;
            if (m_active) begin
                k = cyc - m_tacc;
                e_busy  = 1;
                e_grant = m_owner ? 2'b10 : 2'b01;
                if (m_bad) begin
                    if (k == 1) e_err = 1;
                    if (k == 2) begin
                        if (m_owner) begin e_s1v = 1; e_s1 = m_state; end
                        else begin e_s0v = 1; e_s0 = m_state; end
                        retire = 1;
                    end
                end else if (m_tdone >= 0 && cyc == m_tdone + 1) begin
                    if (m_owner) begin e_s1v = 1; e_s1 = perm_fn(m_state, m_rounds); end
                    else begin e_s0v = 1; e_s0 = perm_fn(m_state, m_rounds); end
                    retire = 1;
                end else if (m_tabort >= 0 && cyc == m_tabort) begin
                    retire = 1;
                end else if (k >= 2) begin
                    e_start = 1;
                    if (perm_done) m_tdone = cyc;
                    else if (k == TO + 1) begin e_err = 1; m_tabort = cyc + 1; end
                end
            end else begin
                if (req0_valid && (!req1_valid || !m_ptr)) e_r0 = 1;
                else if (req1_valid) e_r1 = 1;
            end
            check("req0_ready", {319'd0, req0_ready}, {319'd0, e_r0});
            check("req1_ready", {319'd0, req1_ready}, {319'd0, e_r1});
            check("rsp0_valid", {319'd0, rsp0_valid}, {319'd0, e_s0v});
            check("rsp1_valid", {319'd0, rsp1_valid}, {319'd0, e_s1v});
            check("rsp0_state", rsp0_state, e_s0);
            check("rsp1_state", rsp1_state, e_s1);
            check("perm_start", {319'd0, perm_start}, {319'd0, e_start});
            check("perm_state", perm_state, m_state);
            check("perm_rounds", {315'd0, perm_rounds}, {315'd0, m_rounds});
            check("grant", {318'd0, grant}, {318'd0, e_grant});
            check("busy", {319'd0, busy}, {319'd0, e_busy});
            check("err", {319'd0, err}, {319'd0, e_err});
            if (retire) begin m_active = 0; m_ptr = ~m_ptr; end
            if (e_r0 || e_r1) begin
                m_active = 1; m_tacc = cyc; m_owner = e_r1;
                m_state  = e_r1 ? req1_state : req0_state;
                m_rounds = e_r1 ? req1_rounds : req0_rounds;
                m_bad    = (m_rounds == 5'd0) || (m_rounds > 5'd12);
                m_tdone  = -1; m_tabort = -1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int port, input logic [SW-1:0] s, input logic [RW-1:0] r, output int acc);
        bit got;
        got = 0; acc = -1;
        if (port == 0) begin req0_valid = 1; req0_state = s; req0_rounds = r; end
        else begin req1_valid = 1; req1_state = s; req1_rounds = r; end
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if ((port == 0 && req0_ready) || (port == 1 && req1_ready)) begin got = 1; acc = cyc; end
        end
        if (!got) begin n_tests++; n_fail++; $display("FAIL send_timeout port %0d: no ready within 300 cycles", port); end
        @(posedge clk); #1;
        if (port == 0) req0_valid = 0; else req1_valid = 0;
    endtask

    task automatic wait_rsp(input int port, output logic [SW-1:0] st, output int at);
        bit got;
        got = 0; at = -1; st = '0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (port == 0 && rsp0_valid) begin got = 1; at = cyc; st = rsp0_state; end
            if (port == 1 && rsp1_valid) begin got = 1; at = cyc; st = rsp1_state; end
        end
        if (!got) begin n_tests++; n_fail++; $display("FAIL rsp_timeout port %0d: no response within 200 cycles", port); end
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, a1, at;
        logic [SW-1:0] st;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("reset_grant", {318'd0, grant}, 320'd0);
        check("reset_busy_start", {318'd0, busy, perm_start}, 320'd0);
        idle(1);

        // single request on port 0, 12 rounds
        send(0, {64'h80400c0600000000, 256'd0}, 5'd12, a0);
        wait_rsp(0, st, at);
        check("t1_rsp_value", st, 320'h80400c060000000c);
        check("t1_rsp_latency", 320'(at - a0), 320'd14);
        idle(3);

        // simultaneous pair after reset: port 0 first, port 1 at D+2
        do_reset();
        fork
            send(0, 320'h1111, 5'd6, a0);
            send(1, 320'h2222, 5'd12, a1);
        join
        check("t2_pairA_gap", 320'(a1 - a0), 320'd9);
        idle(20);
        send(0, 320'h3333, 5'd3, a0);
        idle(10);
        fork
            send(0, 320'h4444, 5'd4, a0);
            send(1, 320'h5555, 5'd12, a1);
        join
        check("t2_pairB_gap", 320'(a0 - a1), 320'd15);
        idle(15);

        // illegal round counts on port 1
        send(1, 320'hdead_beef, 5'd0, a1);
        idle(5);
        send(1, 320'hcafe_f00d, 5'd13, a1);
        idle(5);

        // stalled core: watchdog abort, then a normal job
        done_mode = 0;
        send(0, 320'h7777, 5'd12, a0);
        idle(70);
        done_mode = 1;
        send(1, 320'h8888, 5'd5, a1);
        idle(12);

        // reset on the third RUN cycle of a port 0 job
        send(0, 320'h9999, 5'd12, a0);
        idle(3);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("t5_grant_after_rst", {318'd0, grant}, 320'd0);
        check("t5_start_busy_after_rst", {318'd0, perm_start, busy}, 320'd0);
        idle(1);
        fork
            send(0, 320'haaaa, 5'd2, a0);
            send(1, 320'hbbbb, 5'd2, a1);
        join
        check("t5_port0_preferred", {319'd0, a0 < a1}, 320'd1);
        idle(8);

        // spurious done while idle, then a normal job
        spur = 1;
        idle(1);
        spur = 0;
        idle(1);
        send(0, 320'ha5, 5'd8, a0);
        wait_rsp(0, st, at);
        check("t6_rsp_value", st, 320'ha50000000000000008);
        idle(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
